// File: rtl/hyst_pp_pkg.sv
// Shared types and default geometry for the hysteresis-to-Hough ping-pong controller.
package hyst_pp_pkg;

  localparam int DEFAULT_WIDTH  = 1280;
  localparam int DEFAULT_HEIGHT = 720;

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic {
    W_FILL = 1'b0,
    W_WAIT = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } rd_state_t;

endpackage

// File: rtl/pp_bank_tracker.sv
// Holds the state of both frame banks and applies the writer's and reader's
// per-bank transition requests, which may land in the same cycle.
import hyst_pp_pkg::*;

module pp_bank_tracker (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   full_req,
  input  logic                   full_idx,
  input  logic                   fill_req,
  input  logic                   fill_idx,
  input  logic                   drain_req,
  input  logic                   drain_idx,
  input  logic                   empty_req,
  input  logic                   empty_idx,
  output bank_state_t [1:0]      bank_state
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    bank_state_t state_q;
    bank_state_t state_d;

    always_comb begin
      state_d = state_q;
      if (fill_req && (fill_idx == 1'(gi)))   state_d = B_FILLING;
      if (drain_req && (drain_idx == 1'(gi))) state_d = B_DRAINING;
      if (empty_req && (empty_idx == 1'(gi))) state_d = B_EMPTY;
      if (full_req && (full_idx == 1'(gi)))   state_d = B_FULL;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= B_EMPTY;
      else       state_q <= state_d;
    end

    assign bank_state[gi] = state_q;
  end

  // Writer completing and reader releasing the same bank means the two stages lost sync.
  property p_no_bank_collision;
    @(posedge clock) disable iff (reset)
      !(full_req && empty_req && (full_idx == empty_idx));
  endproperty
  a_no_bank_collision: assert property (p_no_bank_collision);

endmodule

// File: rtl/hyst_pingpong_ctrl.sv
// Ping-pong frame-bank controller between hysteresis (writer) and Hough (reader).
// Define HYST_PP_FRAME_CNT_EN to add the frames_written/frames_read counters.
import hyst_pp_pkg::*;

module hyst_pingpong_ctrl #(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [7:0]        wr_data_in,
  input  logic              wr_frame_done,
  output logic              wr_go,
  output logic              bank0_wr_en,
  output logic              bank1_wr_en,
  output logic [ADDR_W-1:0] bank_wr_addr,
  output logic [7:0]        bank_wr_data,
  output logic              rd_start,
  output logic              rd_bank,
  input  logic              rd_done,
  output logic              wr_overrun
`ifdef HYST_PP_FRAME_CNT_EN
  ,
  output logic [15:0]       frames_written,
  output logic [15:0]       frames_read
`endif
);

  wr_state_t         wr_state_q, wr_state_d;
  rd_state_t         rd_state_q, rd_state_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic              bank0_wr_en_q, bank0_wr_en_d;
  logic              bank1_wr_en_q, bank1_wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_go_q, wr_go_d;
  logic              rd_start_q, rd_start_d;
  logic              rd_bank_q, rd_bank_d;
  logic              overrun_q, overrun_d;

  bank_state_t [1:0] bank_state;
  logic              full_req, fill_req, drain_req, empty_req;

  // Requests only look at registered bank state, so a freshly released bank
  // is picked up one cycle later and the final write has always landed first.
  assign full_req  = (wr_state_q == W_FILL) && wr_frame_done;
  assign fill_req  = (wr_state_q == W_WAIT) && (bank_state[wbank_q] == B_EMPTY);
  assign drain_req = (rd_state_q == R_IDLE) && (bank_state[rbank_q] == B_FULL);
  assign empty_req = (rd_state_q == R_BUSY) && rd_done;

  pp_bank_tracker u_tracker (
    .clock      (clock),
    .reset      (reset),
    .full_req   (full_req),
    .full_idx   (wbank_q),
    .fill_req   (fill_req),
    .fill_idx   (wbank_q),
    .drain_req  (drain_req),
    .drain_idx  (rbank_q),
    .empty_req  (empty_req),
    .empty_idx  (rbank_q),
    .bank_state (bank_state)
  );

  always_comb begin
    wr_state_d    = wr_state_q;
    rd_state_d    = rd_state_q;
    wbank_d       = wbank_q;
    rbank_d       = rbank_q;
    wr_go_d       = 1'b0;
    rd_start_d    = 1'b0;
    rd_bank_d     = rd_bank_q;
    wr_addr_d     = wr_addr_in;
    wr_data_d     = wr_data_in;
    bank0_wr_en_d = wr_en_in && (wr_state_q == W_FILL) && !wbank_q;
    bank1_wr_en_d = wr_en_in && (wr_state_q == W_FILL) && wbank_q;
    overrun_d     = overrun_q ||
                    ((wr_state_q == W_WAIT) && (wr_en_in || wr_frame_done));

    unique case (wr_state_q)
      W_FILL: begin
        if (wr_frame_done) begin
          wbank_d    = !wbank_q;
          wr_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (fill_req) begin
          wr_go_d    = 1'b1;
          wr_state_d = W_FILL;
        end
      end
      default: wr_state_d = W_FILL;
    endcase

    unique case (rd_state_q)
      R_IDLE: begin
        if (drain_req) begin
          rd_start_d = 1'b1;
          rd_bank_d  = rbank_q;
          rd_state_d = R_BUSY;
        end
      end
      R_BUSY: begin
        if (rd_done) begin
          rbank_d    = !rbank_q;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state_q    <= W_FILL;
      rd_state_q    <= R_IDLE;
      wbank_q       <= 1'b0;
      rbank_q       <= 1'b0;
      bank0_wr_en_q <= 1'b0;
      bank1_wr_en_q <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_go_q       <= 1'b0;
      rd_start_q    <= 1'b0;
      rd_bank_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      wr_state_q    <= wr_state_d;
      rd_state_q    <= rd_state_d;
      wbank_q       <= wbank_d;
      rbank_q       <= rbank_d;
      bank0_wr_en_q <= bank0_wr_en_d;
      bank1_wr_en_q <= bank1_wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_go_q       <= wr_go_d;
      rd_start_q    <= rd_start_d;
      rd_bank_q     <= rd_bank_d;
      overrun_q     <= overrun_d;
    end
  end

  assign wr_go        = wr_go_q;
  assign bank0_wr_en  = bank0_wr_en_q;
  assign bank1_wr_en  = bank1_wr_en_q;
  assign bank_wr_addr = wr_addr_q;
  assign bank_wr_data = wr_data_q;
  assign rd_start     = rd_start_q;
  assign rd_bank      = rd_bank_q;
  assign wr_overrun   = overrun_q;

`ifdef HYST_PP_FRAME_CNT_EN
  logic [15:0] frames_written_q, frames_written_d;
  logic [15:0] frames_read_q, frames_read_d;

  // 16-bit adders wrap from 0xFFFF to 0 on their own.
  always_comb begin
    frames_written_d = frames_written_q + {15'd0, full_req};
    frames_read_d    = frames_read_q + {15'd0, empty_req};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frames_written_q <= '0;
      frames_read_q    <= '0;
    end else begin
      frames_written_q <= frames_written_d;
      frames_read_q    <= frames_read_d;
    end
  end

  assign frames_written = frames_written_q;
  assign frames_read    = frames_read_q;
`endif

endmodule

// File: tb/tb_hyst_pingpong_ctrl.sv
// Directed bench for hyst_pingpong_ctrl on a 4x3 image: write routing, bank
// hand-over, back-pressure, overrun, simultaneous done pulses and mid-frame reset.
module tb_hyst_pingpong_ctrl;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en_in;
  logic [ADDR_W-1:0] wr_addr_in;
  logic [7:0]        wr_data_in;
  logic              wr_frame_done;
  logic              wr_go;
  logic              bank0_wr_en;
  logic              bank1_wr_en;
  logic [ADDR_W-1:0] bank_wr_addr;
  logic [7:0]        bank_wr_data;
  logic              rd_start;
  logic              rd_bank;
  logic              rd_done;
  logic              wr_overrun;
`ifdef HYST_PP_FRAME_CNT_EN
  logic [15:0]       frames_written;
  logic [15:0]       frames_read;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  hyst_pingpong_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_en_in      (wr_en_in),
    .wr_addr_in    (wr_addr_in),
    .wr_data_in    (wr_data_in),
    .wr_frame_done (wr_frame_done),
    .wr_go         (wr_go),
    .bank0_wr_en   (bank0_wr_en),
    .bank1_wr_en   (bank1_wr_en),
    .bank_wr_addr  (bank_wr_addr),
    .bank_wr_data  (bank_wr_data),
    .rd_start      (rd_start),
    .rd_bank       (rd_bank),
    .rd_done       (rd_done),
    .wr_overrun    (wr_overrun)
`ifdef HYST_PP_FRAME_CNT_EN
    ,
    .frames_written(frames_written),
    .frames_read   (frames_read)
`endif
  );

  // One clock of stimulus; outputs are examined 1 ns after the edge that sampled it.
  task automatic cycle(input logic en, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                       input logic fd, input logic rdd);
    wr_en_in      = en;
    wr_addr_in    = a;
    wr_data_in    = d;
    wr_frame_done = fd;
    rd_done       = rdd;
    @(posedge clock);
    #1;
    $display("txn t=%0t en=%0b addr=%0d data=%02h done=%0b rd_done=%0b -> b0=%0b b1=%0b go=%0b rs=%0b rb=%0b ovr=%0b",
             $time, en, a, d, fd, rdd, bank0_wr_en, bank1_wr_en, wr_go, rd_start, rd_bank, wr_overrun);
    wr_en_in      = 1'b0;
    wr_addr_in    = '0;
    wr_data_in    = '0;
    wr_frame_done = 1'b0;
    rd_done       = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] outs;
    reset = 1'b1;
    wr_en_in = 1'b0; wr_addr_in = '0; wr_data_in = '0; wr_frame_done = 1'b0; rd_done = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    outs = {bank0_wr_en, bank1_wr_en, bank_wr_addr, bank_wr_data, wr_go, rd_start, rd_bank, wr_overrun, 4'b0};
    checks++; if (outs !== 22'd0) $display("FAIL reset_outputs: got %h required 0", outs); else passed++;
`ifdef HYST_PP_FRAME_CNT_EN
    checks++; if ({frames_written, frames_read} !== 32'd0) $display("FAIL reset_counters: got %h required 0", {frames_written, frames_read}); else passed++;
`endif
    reset = 1'b0;
  endtask

  task automatic test_write_path();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, ADDR_W'(i), 8'(8'h10 + i), 1'b0, 1'b0);
      checks++; if ({bank0_wr_en, bank1_wr_en} !== 2'b10) $display("FAIL wr_en_%0d: got %b required 10", i, {bank0_wr_en, bank1_wr_en}); else passed++;
      checks++; if ({bank_wr_addr, bank_wr_data} !== {ADDR_W'(i), 8'(8'h10 + i)}) $display("FAIL wr_addr_data_%0d: got %h/%h required %h/%h", i, bank_wr_addr, bank_wr_data, i, 8'h10 + i); else passed++;
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if ({bank0_wr_en, bank1_wr_en} !== 2'b00) $display("FAIL wr_en_idle: got %b required 00", {bank0_wr_en, bank1_wr_en}); else passed++;
  endtask

  task automatic test_frame0_done();
    for (int i = 4; i < WIDTH * HEIGHT; i++) cycle(1'b1, ADDR_W'(i), 8'(i), (i == WIDTH * HEIGHT - 1), 1'b0);
    checks++; if ({bank0_wr_en, wr_go, rd_start} !== 3'b100) $display("FAIL f0_last_write: got %b required 100", {bank0_wr_en, wr_go, rd_start}); else passed++;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if ({wr_go, rd_start, rd_bank} !== 3'b110) $display("FAIL f0_start_go: got %b required 110", {wr_go, rd_start, rd_bank}); else passed++;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if ({wr_go, rd_start, rd_bank} !== 3'b000) $display("FAIL f0_pulse_end: got %b required 000", {wr_go, rd_start, rd_bank}); else passed++;
  endtask

  task automatic test_back_pressure();
    cycle(1'b1, 4'd0, 8'hAA, 1'b0, 1'b0);
    checks++; if ({bank0_wr_en, bank1_wr_en} !== 2'b01) $display("FAIL f1_bank1_write: got %b required 01", {bank0_wr_en, bank1_wr_en}); else passed++;
    cycle(1'b1, 4'd1, 8'hBB, 1'b1, 1'b0);
    checks++; if ({bank0_wr_en, bank1_wr_en, bank_wr_data} !== {2'b01, 8'hBB}) $display("FAIL f1_last_write: got %b/%h required 01/bb", {bank0_wr_en, bank1_wr_en}, bank_wr_data); else passed++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      checks++; if ({wr_go, rd_start} !== 2'b00) $display("FAIL bp_hold_%0d: got %b required 00", i, {wr_go, rd_start}); else passed++;
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    checks++; if ({wr_go, rd_start} !== 2'b00) $display("FAIL bp_rd_done_edge: got %b required 00", {wr_go, rd_start}); else passed++;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if ({wr_go, rd_start, rd_bank} !== 3'b111) $display("FAIL bp_release: got %b required 111", {wr_go, rd_start, rd_bank}); else passed++;
    cycle(1'b1, 4'd5, 8'hCC, 1'b0, 1'b0);
    checks++; if ({bank0_wr_en, bank1_wr_en} !== 2'b10) $display("FAIL f2_bank0_write: got %b required 10", {bank0_wr_en, bank1_wr_en}); else passed++;
  endtask

  task automatic test_overrun();
    cycle(1'b1, 4'd6, 8'hDD, 1'b1, 1'b0);
    checks++; if ({bank0_wr_en, wr_overrun} !== 2'b10) $display("FAIL f2_last_write: got %b required 10", {bank0_wr_en, wr_overrun}); else passed++;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if ({wr_go, rd_start} !== 2'b00) $display("FAIL ovr_no_go: got %b required 00", {wr_go, rd_start}); else passed++;
    cycle(1'b1, 4'd7, 8'hEE, 1'b0, 1'b0);
    checks++; if ({bank0_wr_en, bank1_wr_en, wr_overrun} !== 3'b001) $display("FAIL ovr_drop: got %b required 001", {bank0_wr_en, bank1_wr_en, wr_overrun}); else passed++;
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      checks++; if ({wr_go, rd_start, wr_overrun} !== 3'b001) $display("FAIL ovr_sticky_%0d: got %b required 001", i, {wr_go, rd_start, wr_overrun}); else passed++;
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if ({wr_go, rd_start, rd_bank} !== 3'b110) $display("FAIL sim_handover: got %b required 110", {wr_go, rd_start, rd_bank}); else passed++;
    cycle(1'b1, 4'd0, 8'h11, 1'b0, 1'b0);
    checks++; if ({bank0_wr_en, bank1_wr_en} !== 2'b01) $display("FAIL sim_bank1_write: got %b required 01", {bank0_wr_en, bank1_wr_en}); else passed++;
    cycle(1'b1, 4'd1, 8'h22, 1'b1, 1'b1);
    checks++; if ({bank0_wr_en, bank1_wr_en, wr_go, rd_start} !== 4'b0100) $display("FAIL sim_edge: got %b required 0100", {bank0_wr_en, bank1_wr_en, wr_go, rd_start}); else passed++;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if ({wr_go, rd_start, rd_bank, wr_overrun} !== 4'b1111) $display("FAIL sim_both_apply: got %b required 1111", {wr_go, rd_start, rd_bank, wr_overrun}); else passed++;
    cycle(1'b1, 4'd2, 8'h33, 1'b0, 1'b0);
    checks++; if ({bank0_wr_en, bank1_wr_en} !== 2'b10) $display("FAIL sim_next_bank0: got %b required 10", {bank0_wr_en, bank1_wr_en}); else passed++;
`ifdef HYST_PP_FRAME_CNT_EN
    checks++; if ({frames_written, frames_read} !== {16'd4, 16'd3}) $display("FAIL frame_counters: got %0d/%0d required 4/3", frames_written, frames_read); else passed++;
`endif
  endtask

  task automatic test_reset_midframe();
    logic [17:0] outs;
    cycle(1'b1, 4'd3, 8'h44, 1'b0, 1'b0);
    wr_en_in = 1'b1; wr_addr_in = 4'd4; wr_data_in = 8'h45;
    reset = 1'b1;
    #1;
    outs = {bank0_wr_en, bank1_wr_en, bank_wr_addr, bank_wr_data, wr_go, rd_start, rd_bank, wr_overrun};
    checks++; if (outs !== 18'd0) $display("FAIL midframe_reset: got %h required 0", outs); else passed++;
    wr_en_in = 1'b0; wr_addr_in = '0; wr_data_in = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cycle(1'b1, 4'd9, 8'h55, 1'b0, 1'b0);
    checks++; if ({bank0_wr_en, bank1_wr_en, bank_wr_addr, wr_overrun} !== {2'b10, 4'd9, 1'b0}) $display("FAIL post_reset_write: got %b/%0d/%b required 10/9/0", {bank0_wr_en, bank1_wr_en}, bank_wr_addr, wr_overrun); else passed++;
    repeat (2) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if ({wr_go, rd_start} !== 2'b00) $display("FAIL post_reset_quiet: got %b required 00", {wr_go, rd_start}); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_path();
    test_frame0_done();
    test_back_pressure();
    test_overrun();
    test_simultaneous();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
